svarog_seq: RTL and testbench

SVAROG_SEQ -- requirements
Module: svarog_seq

---
 rtl/svarog_seq_pkg.sv | 28 ++
 rtl/svarog_seq_if.sv | 30 +++
 rtl/svarog.sv | 2 +
 rtl/svarog_seq.sv | 168 ++++++++++++++++
 tb/tb_svarog_seq.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/svarog_seq_pkg.sv
// Shared types and constants for the svarog signing-job sequencer:
// FSM states, bank map of the svarog register file and job sizes.
package svarog_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR, S_WGAP, S_RUN, S_RGAP, S_BLANK,
        S_POLL, S_RD, S_RCAP, S_PUSH, S_DONE, S_ERR
    } state_e;

    // Parameter banks 0x100..0x600; results come back in banks 0x400/0x500
    localparam logic [5:0][11:0] BANK_BASE = {
        12'h600, 12'h500, 12'h400, 12'h300, 12'h200, 12'h100
    };
    localparam logic [11:0] RUN_ADDR  = 12'h000;
    localparam logic [31:0] CMD_RUN   = 32'h0000_0001;
    localparam int          N_LOAD    = 48;
    localparam int          N_RES     = 16;
    localparam logic [2:0]  SIZE_WORD = 3'd2;

    function automatic logic [11:0] load_addr(input logic [5:0] k);
        return BANK_BASE[k[5:3]] + {7'd0, k[2:0], 2'b00};
    endfunction

    function automatic logic [11:0] res_addr(input logic [3:0] j);
        return (j[3] ? BANK_BASE[4] : BANK_BASE[3]) + {7'd0, j[2:0], 2'b00};
    endfunction

endpackage

// File: rtl/svarog_seq_if.sv
// Parameter/result streams plus the svarog bus, as seen from the sequencer
// (master) and from the svarog core / stream endpoints (slave).
interface svarog_seq_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32
);
    logic                 ld_valid_i;
    logic [DATA_SIZE-1:0] ld_data_i;
    logic                 ld_ready_o;
    logic                 res_valid_o;
    logic [DATA_SIZE-1:0] res_data_o;
    logic                 res_ready_i;
    logic [ADDR_SIZE-1:0] a_o;
    logic                 c_o;
    logic                 w_o;
    logic [2:0]           s_o;
    logic [DATA_SIZE-1:0] d_o;
    logic [DATA_SIZE-1:0] d_i;
    logic                 core_ready_i;

    modport master (
        input  ld_valid_i, ld_data_i, res_ready_i, d_i, core_ready_i,
        output ld_ready_o, res_valid_o, res_data_o, a_o, c_o, w_o, s_o, d_o
    );

    modport slave (
        output ld_valid_i, ld_data_i, res_ready_i, d_i, core_ready_i,
        input  ld_ready_o, res_valid_o, res_data_o, a_o, c_o, w_o, s_o, d_o
    );
endinterface

// File: rtl/svarog.sv
// The svarog core is external to this repository; its bus behaviour is
// provided by the memory-style model in tb/tb_svarog_seq.sv.

// File: rtl/svarog_seq.sv
// Sequencer for one svarog signing job: streams 48 parameter words into the
// core, issues run, waits for ready (with timeout) and streams 16 result words.
module svarog_seq
    import svarog_seq_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int TIMEOUT   = 2_000_000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] cycles_o,
    svarog_seq_if.master bus
);

    localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);

    state_e               state_q, state_d;
    logic [5:0]           k_q, k_d;
    logic [3:0]           j_q, j_d;
    logic                 blank_q, blank_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            blank_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            blank_q <= blank_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Data holding registers are only visible through state-gated outputs
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        blank_d = blank_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_LOAD;
                k_d     = '0;
                j_d     = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            S_LOAD: if (bus.ld_valid_i) begin
                wdata_d = bus.ld_data_i;
                state_d = S_WR;
            end
            S_WR:   state_d = S_WGAP;
            S_WGAP: if (k_q == 6'(N_LOAD - 1)) state_d = S_RUN;
                    else begin
                        k_d     = k_q + 6'd1;
                        state_d = S_LOAD;
                    end
            // cnt_q equals the number of cycles elapsed since the RUN cycle
            S_RUN: begin
                cnt_d   = 32'd1;
                state_d = S_RGAP;
            end
            S_RGAP: begin
                cnt_d   = sat_inc(cnt_q);
                blank_d = 1'b0;
                state_d = S_BLANK;
            end
            S_BLANK: if (cnt_q >= TIMEOUT_CNT) begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end else begin
                cnt_d   = sat_inc(cnt_q);
                blank_d = 1'b1;
                if (blank_q) state_d = S_POLL;
            end
            S_POLL: if (bus.core_ready_i) state_d = S_RD;
                    else if (cnt_q >= TIMEOUT_CNT) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else cnt_d = sat_inc(cnt_q);
            S_RD:   state_d = S_RCAP;
            S_RCAP: begin
                rdata_d = bus.d_i;
                state_d = S_PUSH;
            end
            S_PUSH: if (bus.res_ready_i) begin
                if (j_q == 4'(N_RES - 1)) state_d = S_DONE;
                else begin
                    j_d     = j_q + 4'd1;
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ld_ready_o  = 1'b0;
        bus.res_valid_o = 1'b0;
        bus.res_data_o  = '0;
        bus.a_o         = '0;
        bus.c_o         = 1'b0;
        bus.w_o         = 1'b0;
        bus.s_o         = SIZE_WORD;
        bus.d_o         = '0;
        busy_o          = (state_q != S_IDLE);
        done_o          = 1'b0;
        case (state_q)
            S_LOAD: bus.ld_ready_o = 1'b1;
            S_WR: begin
                bus.c_o = 1'b1;
                bus.w_o = 1'b1;
                bus.a_o = ADDR_SIZE'(load_addr(k_q));
                bus.d_o = wdata_q;
            end
            S_RUN: begin
                bus.c_o = 1'b1;
                bus.w_o = 1'b1;
                bus.a_o = ADDR_SIZE'(RUN_ADDR);
                bus.d_o = DATA_SIZE'(CMD_RUN);
            end
            S_RD: begin
                bus.c_o = 1'b1;
                bus.a_o = ADDR_SIZE'(res_addr(j_q));
            end
            S_PUSH: begin
                bus.res_valid_o = 1'b1;
                bus.res_data_o  = rdata_q;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign err_o    = err_q;
    assign cycles_o = cnt_q;

endmodule

// File: tb/tb_svarog_seq.sv
// Bench for svarog_seq: a memory-style svarog model answers the bus, and job
// outcomes are compared with address/result lists computed from the bank map.
module tb_svarog_seq;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        areset;
    logic        start_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] cycles_o;

    svarog_seq_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    svarog_seq #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .areset(areset), .start_i(start_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .cycles_o(cycles_o), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] ld_words [48];
    logic [31:0] res_words[16];
    logic [255:0] gv[6];
    logic [255:0] rv, sv;
    int  lat = 10;
    bit  stuck = 1'b0;
    int  gap_mode = 0;
    bit  rr_rand = 1'b0;
    bit  hold5 = 1'b0;

    logic [31:0] wa_q[$], wd_q[$], ra_q[$], rq[$];
    logic [31:0] mem[0:1023];
    int  done_cnt = 0;
    int  ld_idx = 0;
    int  bad_idle = 0;
    int  bad_b2b = 0;
    bit  prev_c = 1'b0;
    bit  running = 1'b0;
    int  run_cnt = 0;

    function automatic logic [31:0] exp_wr_addr(input int k);
        return 32'(256 * (k / 8 + 1) + 4 * (k % 8));
    endfunction

    function automatic logic [31:0] exp_rd_addr(input int j);
        return (j < 8) ? 32'(32'h400 + 4 * j) : 32'(32'h500 + 4 * (j - 8));
    endfunction

    // svarog model and bus monitor
    always @(posedge clk) begin
        logic [31:0] t;
        if (areset !== 1'b1) begin
            running = 1'b0;
            bus.core_ready_i <= 1'b0;
            bus.d_i <= '0;
        end else begin
            if (start_i && !busy_o) begin
                wa_q.delete(); wd_q.delete(); ra_q.delete(); rq.delete();
                done_cnt = 0; ld_idx = 0; running = 1'b0;
            end
            if (bus.ld_valid_i && bus.ld_ready_o) ld_idx++;
            if (bus.c_o === 1'b1 && bus.w_o === 1'b1) begin
                wa_q.push_back(bus.a_o);
                wd_q.push_back(bus.d_o);
                if (bus.a_o == 0 && bus.d_o == 1) begin
                    running = 1'b1;
                    run_cnt = 0;
                    for (int j = 0; j < 16; j++) begin
                        t = exp_rd_addr(j);
                        mem[t[11:2]] = res_words[j];
                    end
                end else begin
                    mem[bus.a_o[11:2]] = bus.d_o;
                end
            end
            if (bus.c_o === 1'b1 && bus.w_o === 1'b0) begin
                ra_q.push_back(bus.a_o);
                bus.d_i <= mem[bus.a_o[11:2]];
            end
            if (bus.res_valid_o && bus.res_ready_i) rq.push_back(bus.res_data_o);
            if (done_o === 1'b1) done_cnt++;
            if (running) run_cnt++;
            bus.core_ready_i <= running && !stuck && (run_cnt >= lat);
            if (bus.c_o === 1'b0 && (bus.w_o !== 1'b0 || bus.a_o !== 0 || bus.d_o !== 0)) bad_idle++;
            if (bus.s_o !== 3'd2) bad_idle++;
            if (bus.c_o === 1'b1 && prev_c) bad_b2b++;
        end
        prev_c = (bus.c_o === 1'b1);
    end

    // parameter-word source
    initial begin
        int fcyc = 0;
        bit g;
        bus.ld_valid_i = 1'b0;
        bus.ld_data_i  = '0;
        forever begin
            @(negedge clk);
            fcyc++;
            case (gap_mode)
                0:       g = 1'b1;
                1:       g = (fcyc % 3 == 0);
                default: g = 1'($urandom_range(0, 1));
            endcase
            if (ld_idx < 48 && g) begin
                bus.ld_valid_i = 1'b1;
                bus.ld_data_i  = ld_words[ld_idx];
            end else begin
                bus.ld_valid_i = 1'b0;
                bus.ld_data_i  = '0;
            end
        end
    end

    // result-word sink
    initial begin
        bus.res_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (hold5 && rq.size() == 5) bus.res_ready_i = 1'b0;
            else if (rr_rand)            bus.res_ready_i = 1'($urandom_range(0, 1));
            else                         bus.res_ready_i = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fill();
        for (int k = 0; k < 48; k++) ld_words[k] = $urandom;
        for (int j = 0; j < 16; j++) res_words[j] = $urandom;
    endtask

    task automatic start_job();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && err_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " end in budget"}, 64'(n < budget), 64'd1);
    endtask

    task automatic check_job(input string tag, input int exp_cycles);
        @(negedge clk);
        check({tag, " busy"}, 64'(busy_o), 64'd0);
        check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " err"}, 64'(err_o), 64'd0);
        check({tag, " cycles"}, 64'(cycles_o), 64'(exp_cycles));
        check({tag, " writes"}, 64'(wa_q.size()), 64'd49);
        for (int k = 0; k < 48; k++)
            check($sformatf("%s wr[%0d]", tag, k),
                  (k < wa_q.size()) ? {wa_q[k], wd_q[k]} : 64'hDEAD,
                  {exp_wr_addr(k), ld_words[k]});
        check({tag, " run wr"}, (wa_q.size() > 48) ? {wa_q[48], wd_q[48]} : 64'hDEAD,
              {32'h0, 32'h1});
        check({tag, " reads"}, 64'(ra_q.size()), 64'd16);
        check({tag, " results"}, 64'(rq.size()), 64'd16);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("%s rd[%0d]", tag, j),
                  (j < ra_q.size()) ? 64'(ra_q[j]) : 64'hDEAD, 64'(exp_rd_addr(j)));
            check($sformatf("%s res[%0d]", tag, j),
                  (j < rq.size()) ? 64'(rq[j]) : 64'hDEAD, 64'(res_words[j]));
        end
    endtask

    initial begin
        int n;
        logic [31:0] held;
        int nrd;
        areset  = 1'b0;
        start_i = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst done", 64'(done_o), 64'd0);
        check("rst err", 64'(err_o), 64'd0);
        check("rst cycles", 64'(cycles_o), 64'd0);
        check("rst c/w", {62'd0, bus.c_o, bus.w_o}, 64'd0);
        check("rst a", 64'(bus.a_o), 64'd0);
        check("rst d", 64'(bus.d_o), 64'd0);
        check("rst s", 64'(bus.s_o), 64'd2);
        check("rst ld_ready", 64'(bus.ld_ready_o), 64'd0);
        check("rst res_valid", 64'(bus.res_valid_o), 64'd0);
        check("rst res_data", 64'(bus.res_data_o), 64'd0);
        areset = 1'b1;

        // GOST A.1 vector
        gv[0] = 256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000431;
        gv[1] = 256'h80000000_00000000_00000000_00000001_50FE8A18_92976154_C59CFC19_3ACCF5B3;
        gv[2] = 256'h7A929ADE_789BB9BE_10ED359D_D39A72C1_1B60961F_49397EEE_1D19CE98_91EC3B28;
        gv[3] = 256'd7;
        gv[4] = 256'd2;
        gv[5] = 256'h08E2A8A0_E65147D4_BD631603_0E16D19C_85C97F0A_9CA26712_2B96ABBC_EA7E8FC8;
        rv    = 256'h41AA28D2_F1AB1482_80CD9ED5_6FEDA419_74053554_A42767B8_3AD043FD_39DC0493;
        sv    = 256'h01456C64_BA4642A1_653C235A_98A60249_BCD6D3F7_46B631DF_928014F6_C5BF9C40;
        for (int b = 0; b < 6; b++)
            for (int i = 0; i < 8; i++) ld_words[8 * b + i] = gv[b][32 * i +: 32];
        for (int i = 0; i < 8; i++) begin
            res_words[i]     = rv[32 * i +: 32];
            res_words[8 + i] = sv[32 * i +: 32];
        end
        lat = 30;
        start_job();
        wait_end("gost", 3000);
        check_job("gost", 30);
        check("gost r lsw", (rq.size() > 0) ? 64'(rq[0]) : 64'hDEAD, 64'h39DC0493);
        check("gost r msw", (rq.size() > 7) ? 64'(rq[7]) : 64'hDEAD, 64'h41AA28D2);
        check("gost s msw", (rq.size() > 15) ? 64'(rq[15]) : 64'hDEAD, 64'h01456C64);

        // ld_valid every 3rd cycle, random result back-pressure
        rand_fill();
        gap_mode = 1;
        rr_rand  = 1'b1;
        lat      = $urandom_range(5, 60);
        start_job();
        wait_end("gap3", 3000);
        check_job("gap3", (lat > 4) ? lat : 4);
        check("gap3 bus gaps", 64'(bad_b2b), 64'd0);

        // result word 5 held for 10 cycles
        rand_fill();
        gap_mode = 2;
        rr_rand  = 1'b0;
        hold5    = 1'b1;
        lat      = $urandom_range(5, 60);
        start_job();
        n = 0;
        while (!(bus.res_valid_o === 1'b1 && rq.size() == 5) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("stall reach word5", 64'(n < 3000), 64'd1);
        held = bus.res_data_o;
        nrd  = ra_q.size();
        check("stall word5 value", 64'(held), 64'(res_words[5]));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("stall data c%0d", c),
                  {31'd0, bus.res_valid_o, bus.res_data_o}, {31'd0, 1'b1, held});
            check($sformatf("stall no read c%0d", c), 64'(ra_q.size()), 64'(nrd));
        end
        hold5 = 1'b0;
        wait_end("stall", 3000);
        check_job("stall", (lat > 4) ? lat : 4);

        // core never ready -> timeout
        rand_fill();
        gap_mode = 0;
        stuck    = 1'b1;
        start_job();
        wait_end("tmo", 3000);
        check("tmo err", 64'(err_o), 64'd1);
        check("tmo busy in err", 64'(busy_o), 64'd1);
        check("tmo cycles", 64'(cycles_o), 64'd100);
        @(negedge clk);
        check("tmo back idle", 64'(busy_o), 64'd0);
        check("tmo err sticky", 64'(err_o), 64'd1);
        check("tmo cycles held", 64'(cycles_o), 64'd100);
        check("tmo no reads", 64'(ra_q.size()), 64'd0);
        check("tmo no done", 64'(done_cnt), 64'd0);
        check("tmo writes", 64'(wa_q.size()), 64'd49);

        // reset during the write of word 20
        stuck = 1'b0;
        lat   = 2;
        rand_fill();
        start_job();
        check("err cleared", 64'(err_o), 64'd0);
        check("cycles cleared", 64'(cycles_o), 64'd0);
        n = 0;
        while (!(bus.c_o === 1'b1 && bus.w_o === 1'b1 && wa_q.size() == 20) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst wr20 reached", 64'(n < 2000), 64'd1);
        check("rst wr20 addr", 64'(bus.a_o), 64'(exp_wr_addr(20)));
        areset = 1'b0;
        @(negedge clk);
        check("midrst c/w", {62'd0, bus.c_o, bus.w_o}, 64'd0);
        check("midrst a", 64'(bus.a_o), 64'd0);
        check("midrst busy", 64'(busy_o), 64'd0);
        areset = 1'b1;
        @(negedge clk);

        // restart after reset; ready already high during the blanking cycles
        start_job();
        wait_end("restart", 3000);
        check_job("restart", 4);

        // start pulse during POLL is ignored
        rand_fill();
        lat = 40;
        start_job();
        n = 0;
        while (wa_q.size() < 49 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("poll reach run", 64'(n < 2000), 64'd1);
        repeat (6) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_end("pollstart", 3000);
        check_job("pollstart", 40);
        repeat (3) @(negedge clk);
        check("pollstart stays idle", 64'(busy_o), 64'd0);
        check("pollstart cycles frozen", 64'(cycles_o), 64'd40);

        check("idle bus rules", 64'(bad_idle), 64'd0);
        check("no back-to-back bus", 64'(bad_b2b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
